multicycle_ctrl: RTL and testbench

- Multi-cycle control sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the datapath strobes and muxes: PC, IR, register file, ALU operand selects, memory request and writeback select.
- It decodes the same opcode set as the immediate generator, plus R-type.
- It owns a memory ready/timeout handshake and a retired-instruction counter.

---
 rtl/multicycle_ctrl_if.sv | 32 +++
 rtl/multicycle_ctrl.sv | 129 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the RV32I datapath.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        br_taken;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic        trap;
  logic [2:0]  state;
  logic [31:0] instret;

  modport master (
    input  instr, br_taken, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we, wb_sel,
           alu_a_sel, alu_b_sel, trap, state, instret
  );

  modport slave (
    output instr, br_taken, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we, wb_sel,
           alu_a_sel, alu_b_sel, trap, state, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory timeout,
// sticky trap and retired-instruction counter.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_LUI = 7'd55, OP_AUIPC = 7'd23, OP_JAL = 7'd111, OP_JALR = 7'd103,
                         OP_BR  = 7'd99, OP_LD    = 7'd3,  OP_ST  = 7'd35,  OP_OPI  = 7'd19,
                         OP_OP  = 7'd51;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5
  } state_e;

  state_e        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_instret;
  logic [6:0]    w_op;
  logic          w_ld, w_st, w_legal, w_tmo, w_retire;
  logic          w_mem_req, w_mem_we, w_ir_we, w_pc_we, w_rf_we;

  assign w_op    = bus.instr[6:0];
  assign w_ld    = (w_op == OP_LD);
  assign w_st    = (w_op == OP_ST);
  assign w_legal = (w_op == OP_LUI) || (w_op == OP_AUIPC) || (w_op == OP_JAL) ||
                   (w_op == OP_JALR) || (w_op == OP_BR) || w_ld || w_st ||
                   (w_op == OP_OPI) || (w_op == OP_OP);
  // Trap on the cycle whose not-ready would make the count reach MEM_TIMEOUT.
  assign w_tmo   = (MEM_TIMEOUT > 0) && !bus.mem_ready && ((int'(r_cnt) + 1) >= MEM_TIMEOUT);

  always_comb begin
    w_next           = r_state;
    w_mem_req        = 1'b0;
    w_mem_we         = 1'b0;
    w_ir_we          = 1'b0;
    w_pc_we          = 1'b0;
    w_rf_we          = 1'b0;
    w_retire         = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.pc_sel       = 2'd0;
    bus.wb_sel       = 2'd0;
    bus.alu_a_sel    = 1'b0;
    bus.alu_b_sel    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (w_tmo)              w_next = S_TRAP;
        else if (bus.mem_ready) begin
          w_ir_we = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        bus.alu_a_sel = (w_op == OP_AUIPC) || (w_op == OP_JAL);
        bus.alu_b_sel = (w_op == OP_AUIPC) || (w_op == OP_JAL) || (w_op == OP_OPI) ||
                        w_ld || w_st || (w_op == OP_JALR);
        if (w_op == OP_BR) begin
          w_pc_we    = 1'b1;
          bus.pc_sel = {1'b0, bus.br_taken};
          w_retire   = 1'b1;
          w_next     = S_FETCH;
        end else if (w_ld || w_st) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_mem_req        = 1'b1;
        bus.mem_addr_sel = 1'b1;
        w_mem_we         = w_st;
        if (w_tmo)              w_next = S_TRAP;
        else if (bus.mem_ready) begin
          if (w_st) begin
            w_pc_we  = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        w_rf_we    = 1'b1;
        w_pc_we    = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
        bus.wb_sel = w_ld ? 2'd1 : ((w_op == OP_JAL) || (w_op == OP_JALR)) ? 2'd2 :
                     (w_op == OP_LUI) ? 2'd3 : 2'd0;
        bus.pc_sel = (w_op == OP_JAL) ? 2'd1 : (w_op == OP_JALR) ? 2'd2 : 2'd0;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                           r_cnt <= '0;
    else if ((w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM))) r_cnt <= '0;
    else if (bus.mem_ready)                                               r_cnt <= '0;
    else if (w_mem_req)                                                   r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end

  // Strobes are gated by reset so nothing fires while FETCH is held in reset.
  assign bus.mem_req = w_mem_req & rst_n;
  assign bus.mem_we  = w_mem_we  & rst_n;
  assign bus.ir_we   = w_ir_we   & rst_n;
  assign bus.pc_we   = w_pc_we   & rst_n;
  assign bus.rf_we   = w_rf_we   & rst_n;
  assign bus.trap    = (r_state == S_TRAP);
  assign bus.state   = r_state;
  assign bus.instret = r_instret;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle trace, which is driven and checked.
module tb_multicycle_ctrl;
  localparam int TMO = 15;
  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, T = 3'd5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();
  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  typedef struct packed {
    logic [31:0] ins;
    logic        rdy;
    logic        brt;
    logic [2:0]  st;
    logic [12:0] o;
    logic [31:0] ret;
  } cyc_t;

  cyc_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_ret   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [12:0] obs();
    return {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_we, bus.pc_we, bus.pc_sel,
            bus.rf_we, bus.wb_sel, bus.alu_a_sel, bus.alu_b_sel, bus.trap};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected outputs: req, we, addr_sel, ir_we, pc_we, pc_sel, rf_we, wb_sel, a, b, trap
  task automatic push(input logic [31:0] ins, input logic rdy, input logic brt, input logic [2:0] st,
                      input logic req, input logic we, input logic asel_m, input logic irwe,
                      input logic pcwe, input logic [1:0] pcsel, input logic rfwe,
                      input logic [1:0] wbsel, input logic a, input logic b, input logic tr);
    cyc_t c;
    c.ins = ins; c.rdy = rdy; c.brt = brt; c.st = st; c.ret = m_ret;
    c.o   = {req, we, asel_m, irwe, pcwe, pcsel, rfwe, wbsel, a, b, tr};
    q.push_back(c);
  endtask

  task automatic add_trap(input logic [31:0] ins, input int n);
    for (int i = 0; i < n; i++) push(ins, rb(), rb(), T, 0,0,0,0,0,2'd0,0,2'd0,0,0,1);
  endtask

  // Expand one instruction: wf/wm = not-ready cycles before ready in FETCH/MEM.
  task automatic build(input logic [31:0] ins, input int wf, input int wm, input logic brt);
    logic [6:0] op;
    logic       legal, a, b, ld, st;
    logic [1:0] wbs, pcs;
    op    = ins[6:0];
    legal = op inside {7'd55, 7'd23, 7'd111, 7'd103, 7'd99, 7'd3, 7'd35, 7'd19, 7'd51};
    ld    = (op == 7'd3);
    st    = (op == 7'd35);
    for (int i = 0; i < wf && i < TMO; i++) push(ins, 0, rb(), F, 1,0,0,0,0,2'd0,0,2'd0,0,0,0);
    if (wf >= TMO) begin add_trap(ins, 20); return; end
    push(ins, 1, rb(), F, 1,0,0,1,0,2'd0,0,2'd0,0,0,0);
    push(ins, rb(), rb(), D, 0,0,0,0,0,2'd0,0,2'd0,0,0,0);
    if (!legal) begin add_trap(ins, 20); return; end
    a = (op == 7'd23) || (op == 7'd111);
    b = op inside {7'd23, 7'd111, 7'd19, 7'd3, 7'd35, 7'd103};
    if (op == 7'd99) begin
      push(ins, rb(), brt, E, 0,0,0,0,1,{1'b0, brt},0,2'd0,a,b,0);
      m_ret++;
      return;
    end
    push(ins, rb(), rb(), E, 0,0,0,0,0,2'd0,0,2'd0,a,b,0);
    if (ld || st) begin
      for (int i = 0; i < wm && i < TMO; i++) push(ins, 0, rb(), M, 1,st,1,0,0,2'd0,0,2'd0,0,0,0);
      if (wm >= TMO) begin add_trap(ins, 20); return; end
      push(ins, 1, rb(), M, 1,st,1,0,st,2'd0,0,2'd0,0,0,0);
      if (st) begin m_ret++; return; end
    end
    wbs = ld ? 2'd1 : (op == 7'd111 || op == 7'd103) ? 2'd2 : (op == 7'd55) ? 2'd3 : 2'd0;
    pcs = (op == 7'd111) ? 2'd1 : (op == 7'd103) ? 2'd2 : 2'd0;
    push(ins, rb(), rb(), W, 0,0,0,0,1,pcs,1,wbs,0,0,0);
    m_ret++;
  endtask

  task automatic run_n(input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      @(negedge clk);
      bus.instr = c.ins; bus.mem_ready = c.rdy; bus.br_taken = c.brt;
      #1;
      chk("state", 32'(bus.state), 32'(c.st));
      chk("ctl", 32'(obs()), 32'(c.o));
      chk("instret", bus.instret, c.ret);
    end
  endtask

  task automatic run_q();
    run_n(q.size());
  endtask

  // Reset from mid-cycle; release just after a rising edge so the first
  // driven record lines up with the first cycle out of reset.
  task automatic do_reset();
    #2;
    rst_n = 1'b0; bus.mem_ready = 1'b1;
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_ctl", 32'(obs()), 32'd0);
    chk("rst_instret", bus.instret, 32'd0);
    q.delete();
    m_ret = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [31:0] tbl[9] = '{32'h00500093, 32'h0000A103, 32'h00208463, 32'h00112023, 32'h123450B7,
                          32'h00001097, 32'h008000EF, 32'h000080E7, 32'h002081B3};

  initial begin
    bus.instr = 32'h0; bus.mem_ready = 1'b0; bus.br_taken = 1'b0;
    @(negedge clk);
    do_reset();
    // Directed: zero-wait ADDI, LW with 3 MEM waits, BEQ taken/not-taken
    build(32'h00500093, 0, 0, 1'b0);
    build(32'h0000A103, 0, 3, 1'b0);
    build(32'h00208463, 0, 0, 1'b1);
    build(32'h00208463, 0, 0, 1'b0);
    run_q();
    // Random instruction stream, including ready on the last allowed cycle
    for (int k = 0; k < 60; k++) begin
      build(tbl[$urandom_range(0, 8)],
            ($urandom_range(0, 5) == 0) ? TMO - 1 : int'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0) ? TMO - 1 : int'($urandom_range(0, 3)), rb());
      run_q();
    end
    // Illegal opcode: sticky trap with frozen instret
    build(32'h0000007F, 1, 0, 1'b0);
    run_q();
    do_reset();
    // FETCH timeout after exactly TMO request cycles
    build(32'h00500093, 0, 0, 1'b0);
    build(32'h00500093, TMO, 0, 1'b0);
    run_q();
    do_reset();
    // MEM timeout on a load
    build(32'h0000A103, 2, TMO, 1'b0);
    run_q();
    do_reset();
    // Reset in the middle of an SW's MEM phase
    build(32'h00500093, 0, 0, 1'b0);
    build(32'h00112023, 0, 3, 1'b0);
    run_n(9);
    chk("pre_rst_memreq", 32'(bus.mem_req), 32'd1);
    do_reset();
    build(32'h00500093, 1, 0, 1'b0);
    build(32'h00112023, 0, 0, 1'b0);
    run_q();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
